gamma_mux_scheduler: RTL and testbench
======================================

Name: gamma_mux_scheduler

Overview:
Controller that time-multiplexes one shared macro-column across NUM_NETS networks within each gamma cycle. It generates the gamma-cycle timebase (grst, gamma_count) and per-network slot grants. It also drives the ping-pong buffer select and replay-enable controls for the downstream replay buffer/demux. It sequences the prime, run and drain phases so that replay output is only valid once a full gamma cycle has been captured.

Parameters:
NUM_NETS, 2, number of networks sharing the column (≥2)
GAMMA_CYCLE_LENGTH, 18, cycles per gamma cycle; must be divisible by NUM_NETS
SLOT_LEN, GAMMA_CYCLE_LENGTH/NUM_NETS, cycles per network slot (derived, ≥2)

Ports:
clk  in  1  clock; single clock domain
rstb  in  1  synchronous, active-high reset
en  in  1  run request; sampled only at gamma boundaries (and in IDLE)
net_req  in  NUM_NETS  per-network "has input this gamma" request
grst  out  1  one-cycle pulse on the first cycle of each gamma cycle
gamma_count  out  $clog2(GAMMA_CYCLE_LENGTH)  cycle index within gamma, 0..G-1
slot_count  out  $clog2(SLOT_LEN)  cycle index within slot, 0..SLOT_LEN-1
net_sel  out  $clog2(NUM_NETS)  index of network owning the current slot
net_grant  out  NUM_NETS  one-hot grant, held for the whole slot
col_clr  out  1  pulse on the first cycle of every granted or idle slot (column state clear)
buf_sel  out  1  ping-pong write bank select
start_count  out  1  replay counter enable for the buffer
replay_valid  out  1  replay outputs meaningful
busy  out  1  state != IDLE

Behaviour:
- Reset (rstb=1 at posedge): state=IDLE. All outputs 0, including counters, buf_sel and net_grant. Reset mid-operation aborts immediately; there is no drain.
- States: IDLE, PRIME, RUN, DRAIN.
- IDLE: counters held at 0. en=1 sampled -> PRIME next cycle; that first PRIME cycle has gamma_count=0 and grst=1.
- Counters in PRIME/RUN/DRAIN:
  - gamma_count increments every cycle and wraps G-1 -> 0.
  - slot_count wraps SLOT_LEN-1 -> 0.
  - net_sel increments on each slot wrap and wraps NUM_NETS-1 -> 0 together with the gamma wrap.
  - net_sel=0 whenever gamma_count=0.
- grst=1 iff gamma_count==0 and state != IDLE.
- Slot grant:
  - net_grant[net_sel] = net_req[net_sel] as registered on the cycle the slot begins; held constant for SLOT_LEN cycles.
  - A req change mid-slot has no effect. No req -> idle slot, net_grant=0.
  - col_clr=1 on slot_count==0 in PRIME/RUN regardless of grant.
- buf_sel: 0 on PRIME entry; toggles at every gamma wrap (the cycle gamma_count returns to 0) while in PRIME/RUN/DRAIN.
- PRIME: exactly one gamma cycle; start_count=0, replay_valid=0. At wrap -> RUN if en=1, else DRAIN.
- RUN: start_count=1, replay_valid=1, grants active. At wrap -> DRAIN if en=0, else remain in RUN.
- DRAIN: exactly one gamma cycle; net_grant=0, col_clr=0, start_count=1, replay_valid=1. At wrap -> IDLE, with all outputs back to reset values.
- en changes mid-gamma are ignored until the wrap. en=1 during DRAIN is ignored; re-sampled in IDLE, giving a minimum of 1 IDLE cycle.
- All outputs are registered; zero combinational paths from inputs to outputs.

Optional Feature:
MUX_SCHED_STATS_EN
- Defined: adds output gamma_done_cnt[15:0]. Increments at every gamma wrap in PRIME/RUN/DRAIN, saturates at 16'hFFFF, cleared only by rstb.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Defaults; rstb 3 cycles, then en=1 held, net_req=2'b11 -> PRIME starts 1 cycle after en.
  - grst at gamma_count=0 every 18 cycles.
  - net_grant=01 for gamma_count 0–8, 10 for 9–17.
  - col_clr at gamma_count 0 and 9.
  - replay_valid/start_count rise at the start of the 2nd gamma cycle.
- net_req=2'b10 constant in RUN -> net_grant=00 for gamma_count 0–8 with col_clr still pulsing at 0; grant=10 for 9–17. A net_req[0] pulse at gamma_count=4 causes no grant.
- en dropped at gamma_count=5 in RUN -> RUN completes to 17, then DRAIN for 18 cycles with net_grant=0 and replay_valid=1, then IDLE with busy=0 and all outputs 0.
- buf_sel check over 4 gammas from PRIME: 0,1,0,1, toggling exactly at each grst cycle.
- rstb=1 at gamma_count=11 in RUN -> next cycle all outputs 0 and state IDLE. With en still 1, PRIME restarts the cycle after rstb deasserts.
- STATS_EN build: 3 full gammas then reset -> gamma_done_cnt=3, then 0. Force the counter near 16'hFFFF -> it saturates.

Source files
------------

// File: rtl/gamma_mux_scheduler.sv
// Gamma-cycle timebase and per-network slot scheduler for one shared column: IDLE/PRIME/RUN/DRAIN, ping-pong bank and replay control.
// Outputs registered, one cycle from sampled inputs; no backpressure. Define MUX_SCHED_STATS_EN to add the saturating gamma_done_cnt output.
module gamma_mux_scheduler #(
   parameter int NUM_NETS           = 2,
   parameter int GAMMA_CYCLE_LENGTH = 18,
   parameter int SLOT_LEN           = GAMMA_CYCLE_LENGTH / NUM_NETS
) (
   input  logic                                  clk,
   input  logic                                  rstb,
   input  logic                                  en,
   input  logic [NUM_NETS-1:0]                   net_req,
   output logic                                  grst,
   output logic [$clog2(GAMMA_CYCLE_LENGTH)-1:0] gamma_count,
   output logic [$clog2(SLOT_LEN)-1:0]           slot_count,
   output logic [$clog2(NUM_NETS)-1:0]           net_sel,
   output logic [NUM_NETS-1:0]                   net_grant,
   output logic                                  col_clr,
   output logic                                  buf_sel,
   output logic                                  start_count,
   output logic                                  replay_valid,
   output logic                                  busy
`ifdef MUX_SCHED_STATS_EN
   ,
   output logic [15:0]                           gamma_done_cnt
`endif
);

   localparam int GW = $clog2(GAMMA_CYCLE_LENGTH);
   localparam int SW = $clog2(SLOT_LEN);
   localparam int NW = $clog2(NUM_NETS);

   typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_DRAIN} state_t;

   state_t              r_state;
   logic [GW-1:0]       r_gamma;
   logic [SW-1:0]       r_slot;
   logic [NW-1:0]       r_sel;
   logic [NUM_NETS-1:0] r_grant;
   logic                r_grst;
   logic                r_col_clr;
   logic                r_buf_sel;
   logic                r_replay;

   state_t              w_state_nxt;
   logic                w_gwrap;
   logic                w_swrap;
   logic [GW-1:0]       w_gamma_nxt;
   logic [SW-1:0]       w_slot_nxt;
   logic [NW-1:0]       w_sel_nxt;
   logic [NUM_NETS-1:0] w_grant_nxt;

   always_comb begin
      w_gwrap     = (r_gamma == GW'(GAMMA_CYCLE_LENGTH - 1));
      w_swrap     = (r_slot == SW'(SLOT_LEN - 1));
      w_gamma_nxt = w_gwrap ? '0 : r_gamma + 1'b1;
      w_slot_nxt  = w_swrap ? '0 : r_slot + 1'b1;
      // Slot index is forced back to 0 on the gamma wrap so it stays aligned to grst.
      w_sel_nxt   = w_gwrap ? '0 : (w_swrap ? r_sel + 1'b1 : r_sel);
      w_grant_nxt = net_req & (NUM_NETS'(1) << w_sel_nxt);
      w_state_nxt = r_state;
      if (r_state != S_IDLE && w_gwrap) begin
         case (r_state)
            S_PRIME, S_RUN: w_state_nxt = en ? S_RUN : S_DRAIN;
            default:        w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rstb || (r_state == S_IDLE && !en) || (r_state != S_IDLE && w_state_nxt == S_IDLE)) begin
         r_state   <= S_IDLE;
         r_gamma   <= '0;
         r_slot    <= '0;
         r_sel     <= '0;
         r_grant   <= '0;
         r_grst    <= 1'b0;
         r_col_clr <= 1'b0;
         r_buf_sel <= 1'b0;
         r_replay  <= 1'b0;
      end else if (r_state == S_IDLE) begin
         r_state   <= S_PRIME;
         r_gamma   <= '0;
         r_slot    <= '0;
         r_sel     <= '0;
         r_grant   <= net_req & NUM_NETS'(1);
         r_grst    <= 1'b1;
         r_col_clr <= 1'b1;
         r_buf_sel <= 1'b0;
         r_replay  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_gamma   <= w_gamma_nxt;
         r_slot    <= w_slot_nxt;
         r_sel     <= w_sel_nxt;
         r_grst    <= w_gwrap;
         r_buf_sel <= w_gwrap ? ~r_buf_sel : r_buf_sel;
         r_replay  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
         r_col_clr <= w_swrap && (w_state_nxt != S_DRAIN);
         // Grant is captured only at slot start; DRAIN slots never grant.
         if (w_swrap)
            r_grant <= (w_state_nxt == S_DRAIN) ? '0 : w_grant_nxt;
      end
   end

   assign grst         = r_grst;
   assign gamma_count  = r_gamma;
   assign slot_count   = r_slot;
   assign net_sel      = r_sel;
   assign net_grant    = r_grant;
   assign col_clr      = r_col_clr;
   assign buf_sel      = r_buf_sel;
   assign start_count  = r_replay;
   assign replay_valid = r_replay;
   assign busy         = (r_state != S_IDLE);

`ifdef MUX_SCHED_STATS_EN
   logic [15:0] r_gdone;

   always_ff @(posedge clk) begin
      if (rstb)
         r_gdone <= '0;
      else if (r_state != S_IDLE && w_gwrap && r_gdone != 16'hFFFF)
         r_gdone <= r_gdone + 16'd1;
   end

   assign gamma_done_cnt = r_gdone;
`endif

endmodule

// File: tb/tb_gamma_mux_scheduler.sv
// Randomized bench for gamma_mux_scheduler against an elapsed-time reference model.
module tb_gamma_mux_scheduler;

   localparam int NN = 2;
   localparam int G  = 18;
   localparam int S  = G / NN;

   logic          clk = 1'b0;
   logic          rstb;
   logic          en;
   logic [NN-1:0] net_req;
   logic          grst;
   logic [4:0]    gamma_count;
   logic [3:0]    slot_count;
   logic [0:0]    net_sel;
   logic [NN-1:0] net_grant;
   logic          col_clr;
   logic          buf_sel;
   logic          start_count;
   logic          replay_valid;
   logic          busy;
`ifdef MUX_SCHED_STATS_EN
   logic [15:0]   gamma_done_cnt;
`endif

   gamma_mux_scheduler dut (
      .clk          (clk),
      .rstb         (rstb),
      .en           (en),
      .net_req      (net_req),
      .grst         (grst),
      .gamma_count  (gamma_count),
      .slot_count   (slot_count),
      .net_sel      (net_sel),
      .net_grant    (net_grant),
      .col_clr      (col_clr),
      .buf_sel      (buf_sel),
      .start_count  (start_count),
      .replay_valid (replay_valid),
      .busy         (busy)
`ifdef MUX_SCHED_STATS_EN
      ,
      .gamma_done_cnt (gamma_done_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_bad = 0;

   // Reference: phase 0 idle, 1 prime, 2 run, 3 drain; time measured from PRIME start.
   bit            m_act = 1'b0;
   int            m_cyc = 0;
   int            m_gidx = 0;
   int            m_ph = 0;
   logic [NN-1:0] m_req = '0;
   int            m_gdone = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d want %0d at t=%0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_update();
      if (rstb) begin
         m_act = 1'b0; m_cyc = 0; m_gidx = 0; m_ph = 0; m_req = '0; m_gdone = 0;
      end else if (!m_act) begin
         if (en) begin
            m_act = 1'b1; m_cyc = 0; m_gidx = 0; m_ph = 1; m_req = net_req;
         end
      end else begin
         m_cyc++;
         if (m_cyc % G == 0) begin
            if (m_gdone < 65535) m_gdone++;
            m_gidx++;
            if (m_ph == 3) begin
               m_act = 1'b0; m_ph = 0; m_cyc = 0; m_gidx = 0;
            end else begin
               m_ph = en ? 2 : 3;
            end
         end
         if (m_act && (m_cyc % S == 0)) m_req = net_req;
      end
   endtask

   task automatic compare_all();
      int gc, sl, sel, gnt;
      bit capt;
      gc   = m_act ? (m_cyc % G) : 0;
      sl   = gc % S;
      sel  = gc / S;
      capt = (m_ph == 1) || (m_ph == 2);
      gnt  = (capt && m_req[sel]) ? (1 << sel) : 0;
      chk("busy",         32'(busy),         int'(m_act));
      chk("gamma_count",  32'(gamma_count),  gc);
      chk("slot_count",   32'(slot_count),   sl);
      chk("net_sel",      32'(net_sel),      sel);
      chk("grst",         32'(grst),         (m_act && gc == 0) ? 1 : 0);
      chk("net_grant",    32'(net_grant),    gnt);
      chk("col_clr",      32'(col_clr),      (capt && sl == 0) ? 1 : 0);
      chk("buf_sel",      32'(buf_sel),      m_act ? (m_gidx % 2) : 0);
      chk("start_count",  32'(start_count),  (m_ph >= 2) ? 1 : 0);
      chk("replay_valid", 32'(replay_valid), (m_ph >= 2) ? 1 : 0);
`ifdef MUX_SCHED_STATS_EN
      chk("gamma_done_cnt", 32'(gamma_done_cnt), m_gdone);
`endif
   endtask

   // One clock: model sees the same inputs the DUT samples, outputs checked at the falling edge.
   task automatic step();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare_all();
   endtask

   task automatic wait_gc(input int n);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 3 * G && !hit; i++) begin
         if (busy && int'(gamma_count) == n) hit = 1'b1;
         else step();
      end
      if (!hit) chk("wait_gc_timeout", 0, 1);
   endtask

   initial begin
      rstb = 1'b1; en = 1'b0; net_req = '0;
      repeat (3) step();
      rstb = 1'b0; en = 1'b1; net_req = 2'b11;
      repeat (4 * G + 2) step();

      net_req = 2'b10;
      step();
      wait_gc(4);
      net_req = 2'b11;
      step();
      net_req = 2'b10;
      repeat (G) step();

      wait_gc(5);
      en = 1'b0;
      repeat (2 * G + 4) step();

      en = 1'b1;
      repeat (2 * G) step();
      wait_gc(11);
      rstb = 1'b1;
      step();
      rstb = 1'b0;
      repeat (2 * G) step();

      rstb = 1'b1;
      step();
      rstb = 1'b0; en = 1'b1;
      repeat (3 * G + 1) step();
      rstb = 1'b1;
      step();
      rstb = 1'b0; en = 1'b0;
      step();

      repeat (3000) begin
         net_req = NN'($urandom);
         if ($urandom_range(0, 39) == 0) en = ~en;
         rstb = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
